// File: rtl/sync_down_counter_tff_if.sv
// Control/status bundle for one sync_down_counter_tff stage.
// master drives en/load/d; the counter (slave) returns q/tc/done.
interface sync_down_counter_tff_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;

    modport master (output en, load, d, input q, tc, done);
    modport slave  (input en, load, d, output q, tc, done);
endinterface

// File: rtl/sync_down_counter_tff.sv
// Modulo-MODULUS down counter built as a T-FF chain, state updated on the falling clock edge.
// tc is the combinational borrow used to enable the next cascaded stage.
module sync_down_counter_tff #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rs,
    sync_down_counter_tff_if.slave bus
);

    localparam int unsigned      CW    = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam bit               POW2  = (64'(MODULUS) == (64'd1 << WIDTH));

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] low_zero;
    logic [WIDTH-1:0] toggle;
    logic             done_r;
    logic             done_nxt;
    logic             at_zero;

    // low_zero[i]: all bits below i are zero (borrow ripple into bit i)
    always_comb begin
        low_zero    = '0;
        low_zero[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            low_zero[i] = low_zero[i-1] & ~q_r[i-1];
        end
    end

    assign at_zero = (q_r == '0);

    // Next state: load (with clamp) beats count; done freezes the count
    always_comb begin
        toggle   = {WIDTH{bus.en}} & low_zero;
        q_nxt    = q_r;
        done_nxt = done_r;
        if (bus.load) begin
            q_nxt    = ({1'b0, bus.d} >= CW'(MODULUS)) ? MAX_Q : bus.d;
            done_nxt = 1'b0;
        end else if (bus.en && !done_r) begin
            if (at_zero) begin
                if (ONE_SHOT) begin
                    toggle   = '0;
                    done_nxt = 1'b1;
                end else if (!POW2) begin
                    toggle = q_r ^ MAX_Q;
                end
            end
            q_nxt = q_r ^ toggle;
        end
    end

    always_ff @(negedge clk) begin
        if (rs) begin
            q_r    <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            done_r <= done_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.done = done_r;
    assign bus.tc   = bus.en & at_zero & ~done_r;

endmodule

// File: tb/tb_sync_down_counter_tff.sv
// Bench for sync_down_counter_tff: free-run, one-shot and a two-digit BCD cascade.
// Inputs change just after the rising edge; state is checked on the next rising edge.
module tb_sync_down_counter_tff;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MODULUS = 10;

    logic clk = 1'b0;
    logic rs  = 1'b0;

    always #5 clk = ~clk;

    sync_down_counter_tff_if #(.WIDTH(WIDTH)) m_if ();
    sync_down_counter_tff_if #(.WIDTH(WIDTH)) o_if ();
    sync_down_counter_tff_if #(.WIDTH(WIDTH)) u_if ();
    sync_down_counter_tff_if #(.WIDTH(WIDTH)) t_if ();

    assign t_if.en = u_if.tc;

    sync_down_counter_tff #(.WIDTH(WIDTH), .MODULUS(MODULUS), .ONE_SHOT(1'b0))
        dut_main  (.clk(clk), .rs(rs), .bus(m_if));
    sync_down_counter_tff #(.WIDTH(WIDTH), .MODULUS(MODULUS), .ONE_SHOT(1'b1))
        dut_os    (.clk(clk), .rs(rs), .bus(o_if));
    sync_down_counter_tff #(.WIDTH(WIDTH), .MODULUS(MODULUS), .ONE_SHOT(1'b0))
        dut_units (.clk(clk), .rs(rs), .bus(u_if));
    sync_down_counter_tff #(.WIDTH(WIDTH), .MODULUS(MODULUS), .ONE_SHOT(1'b0))
        dut_tens  (.clk(clk), .rs(rs), .bus(t_if));

    // sel: 0 = free-running stage, 1 = one-shot stage, 2 = tens/units cascade
    typedef struct {
        int unsigned sel;
        bit          rs;
        bit          en;
        bit          load;
        logic [7:0]  d;
        logic [7:0]  q;
        bit          chk_tc;
        bit          tc;
        bit          done;
    } vec_t;

    typedef struct {
        int unsigned sel;
        logic [7:0]  q;
        bit          done;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   armed  = 1'b0;

    function automatic void add(input int unsigned sel, input bit r, input bit e, input bit l,
                                input logic [7:0] d, input logic [7:0] q, input bit chk,
                                input bit tc, input bit done);
        vec_t v;
        v = '{sel, r, e, l, d, q, chk, tc, done};
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic act_tc;
        exp_t e;
        @(posedge clk);
        #1;
        rs        = v.rs;
        m_if.en   = (v.sel == 0) ? v.en : 1'b0;
        m_if.load = (v.sel == 0) ? v.load : 1'b0;
        m_if.d    = v.d[3:0];
        o_if.en   = (v.sel == 1) ? v.en : 1'b0;
        o_if.load = (v.sel == 1) ? v.load : 1'b0;
        o_if.d    = v.d[3:0];
        u_if.en   = (v.sel == 2) ? v.en : 1'b0;
        u_if.load = (v.sel == 2) ? v.load : 1'b0;
        u_if.d    = v.d[3:0];
        t_if.load = (v.sel == 2) ? v.load : 1'b0;
        t_if.d    = v.d[7:4];
        #1;
        if (v.chk_tc) begin
            act_tc = (v.sel == 0) ? m_if.tc : (v.sel == 1) ? o_if.tc : u_if.tc;
            checks++;
            if (act_tc !== v.tc) begin
                errors++;
                $display("FAIL tc step %0d sel %0d: got %b expected %b", idx, v.sel, act_tc, v.tc);
            end
        end
        e = '{v.sel, v.q, v.done, idx};
        sb.push_back(e);
    endtask

    // Scoreboard: compare state after the falling edge, plus a range check on every stage
    always @(posedge clk) begin : mon
        exp_t       e;
        logic [7:0] aq;
        logic       ad;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin aq = {4'b0, m_if.q};  ad = m_if.done; end
                1:       begin aq = {4'b0, o_if.q};  ad = o_if.done; end
                default: begin aq = {t_if.q, u_if.q}; ad = u_if.done | t_if.done; end
            endcase
            checks++;
            if (aq !== e.q || ad !== e.done) begin
                errors++;
                $display("FAIL state step %0d sel %0d: got q=%h done=%b expected q=%h done=%b",
                         e.idx, e.sel, aq, ad, e.q, e.done);
            end
        end
        if (armed) begin
            checks++;
            if (!(m_if.q < WIDTH'(MODULUS)) || !(o_if.q < WIDTH'(MODULUS)) ||
                !(u_if.q < WIDTH'(MODULUS)) || !(t_if.q < WIDTH'(MODULUS))) begin
                errors++;
                $display("FAIL range: got q=%0d/%0d/%0d/%0d required all < %0d",
                         m_if.q, o_if.q, u_if.q, t_if.q, MODULUS);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seq[12];
        int   v;
        int   n;
        vec_t cv;

        m_if.en = 1'b0; m_if.load = 1'b0; m_if.d = '0;
        o_if.en = 1'b0; o_if.load = 1'b0; o_if.d = '0;
        u_if.en = 1'b0; u_if.load = 1'b0; u_if.d = '0;
        t_if.load = 1'b0; t_if.d = '0;

        // reset with en/load/d asserted: load ignored, tc follows en once q is 0
        add(0, 1, 1, 1, 8'd7, 8'd0, 0, 0, 0);
        add(0, 1, 1, 1, 8'd7, 8'd0, 1, 1, 0);
        // free-run from 3 across the wrap
        add(0, 0, 0, 1, 8'd3, 8'd3, 1, 0, 0);
        seq = '{2, 1, 0, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        for (int i = 0; i < 12; i++) add(0, 0, 1, 0, 8'd0, 8'(seq[i]), 1, (i == 3), 0);
        // clamp and load-over-en priority
        add(0, 0, 1, 1, 8'd13, 8'd9, 1, 0, 0);
        add(0, 0, 1, 0, 8'd0,  8'd8, 1, 0, 0);
        add(0, 0, 0, 1, 8'd10, 8'd9, 1, 0, 0);
        add(0, 0, 1, 1, 8'd9,  8'd9, 1, 0, 0);
        // en 1,0,1 from 6, then reset at 4
        add(0, 0, 0, 1, 8'd6, 8'd6, 1, 0, 0);
        add(0, 0, 1, 0, 8'd0, 8'd5, 1, 0, 0);
        add(0, 0, 0, 0, 8'd0, 8'd5, 1, 0, 0);
        add(0, 0, 1, 0, 8'd0, 8'd4, 1, 0, 0);
        add(0, 1, 1, 0, 8'd0, 8'd0, 1, 0, 0);
        add(0, 0, 0, 0, 8'd0, 8'd0, 1, 0, 0);
        add(0, 0, 1, 0, 8'd0, 8'd9, 1, 1, 0);
        // one-shot: run to 0, stop, reload, then rs clears done
        add(1, 0, 0, 1, 8'd2, 8'd2, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd1, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 1, 1);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 1);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 1);
        add(1, 0, 1, 1, 8'd5, 8'd5, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd4, 1, 0, 0);
        add(1, 0, 0, 1, 8'd0, 8'd0, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 1, 1);
        add(1, 1, 1, 0, 8'd0, 8'd0, 1, 0, 0);
        add(1, 0, 1, 0, 8'd0, 8'd0, 1, 1, 1);
        add(1, 0, 0, 0, 8'd0, 8'd0, 1, 0, 1);

        n = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], n);
            n++;
            if (n == 2) armed = 1'b1;
        end

        // cascade: load 20, then 21 unit pulses down through 00 to 99
        cv = '{2, 0, 0, 1, 8'h20, 8'h20, 1, 0, 0};
        apply(cv, n);
        n++;
        v = 20;
        for (int k = 0; k < 21; k++) begin
            cv.load   = 1'b0;
            cv.en     = 1'b1;
            cv.d      = 8'h00;
            cv.tc     = ((v % 10) == 0);
            v         = (v == 0) ? 99 : v - 1;
            cv.q      = {4'(v / 10), 4'(v % 10)};
            apply(cv, n);
            n++;
        end

        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
